// File: rtl/wb_daq_channel.sv
// DAQ channel data mover: ADC samples -> FIFO -> Wishbone B3 single writes.
// Optional `DAQ_CHANNEL_PACK_EN packs two 16-bit samples per 32-bit word.
module wb_daq_channel #(
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int FIFO_AW = 3
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [31:0]   control_reg,
  input  logic [31:0]   address_reg,
  output logic [31:0]   status_reg,
  input  logic          sample_valid,
  input  logic [15:0]   sample_data,
  output logic          done_irq,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t state, state_d;

  logic          en_q, en_qq, rise;
  logic [aw-1:0] base;
  logic [15:0]   length, count;
  logic          circ;
  logic          busy, done, overflow, bus_err;

  logic          start, zstart, wr_ack, wr_err;
  logic          blk_done, stop, flush;

  logic [dw-1:0]    mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             empty, full;
  logic             push_req, push_ok, pop;
  logic [31:0]      push_word;
  logic [dw-1:0]    head;

  logic unused_in;
  assign unused_in = ^{wb_dat_i, control_reg[15:2], address_reg[1:0]};

  assign rise  = en_q & ~en_qq;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[FIFO_AW], rd_ptr[FIFO_AW-1:0]});
  assign head  = mem[rd_ptr[FIFO_AW-1:0]];
  assign pop   = wr_ack;
  assign flush = stop | start | zstart;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push_req & (~full | pop);

`ifdef DAQ_CHANNEL_PACK_EN
  logic        half;
  logic [15:0] pack_lo;

  assign push_req  = sample_valid & busy & half;
  assign push_word = {sample_data, pack_lo};

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      half    <= 1'b0;
      pack_lo <= 16'h0;
    end else if (flush) begin
      half <= 1'b0;
    end else if (sample_valid && busy) begin
      if (!half) pack_lo <= sample_data;
      half <= ~half;
    end
  end
`else
  assign push_req  = sample_valid & busy;
  assign push_word = {16'h0, sample_data};
`endif

  always_ff @(posedge wb_clk) begin
    if (push_ok && !flush)
      mem[wr_ptr[FIFO_AW-1:0]] <= push_word;
  end

  always_comb begin
    state_d  = state;
    start    = 1'b0;
    zstart   = 1'b0;
    wr_ack   = 1'b0;
    wr_err   = 1'b0;
    blk_done = 1'b0;
    stop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          if (control_reg[31:16] == 16'h0) begin
            zstart = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (!control_reg[0]) begin
          stop    = 1'b1;
          state_d = IDLE;
        end else if (!empty) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (wb_err_i) begin
          wr_err  = 1'b1;
          stop    = 1'b1;
          state_d = IDLE;
        end else if (wb_ack_i) begin
          wr_ack  = 1'b1;
          state_d = GAP;
        end else if (wb_rty_i) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (count == length) begin
          blk_done = 1'b1;
          state_d  = circ ? ARM : IDLE;
        end else if (control_reg[0]) begin
          state_d = ARM;
        end else begin
          stop    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state    <= IDLE;
      // Enable held high through reset must not look like a new edge.
      en_q     <= control_reg[0];
      en_qq    <= control_reg[0];
      base     <= '0;
      length   <= 16'h0;
      count    <= 16'h0;
      circ     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
      done_irq <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_d;
      en_q     <= control_reg[0];
      en_qq    <= en_q;
      done_irq <= zstart | blk_done;
      if (start || zstart) begin
        base     <= {address_reg[aw-1:2], 2'b00};
        length   <= control_reg[31:16];
        circ     <= control_reg[1];
        count    <= 16'h0;
        done     <= zstart;
        overflow <= 1'b0;
        bus_err  <= 1'b0;
      end
      if (start) busy <= 1'b1;
      if (wr_ack) count <= count + 16'd1;
      if (wr_err) bus_err <= 1'b1;
      if (blk_done) begin
        done <= 1'b1;
        if (circ) count <= 16'h0;
        else      busy  <= 1'b0;
      end
      if (stop) busy <= 1'b0;
      if (push_req && full && !pop) overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  logic in_wr;
  assign in_wr = (state == WRITE);

  assign wb_cyc_o = in_wr;
  assign wb_stb_o = in_wr;
  assign wb_we_o  = in_wr;
  assign wb_sel_o = in_wr ? 4'hF : 4'h0;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;
  assign wb_adr_o = in_wr ? base + aw'({count, 2'b00}) : '0;
  assign wb_dat_o = in_wr ? head : '0;

  assign status_reg = {count, 12'h0, bus_err, overflow, done, busy};

endmodule
